// File: rtl/fig_14_nibble_serial_adder_pkg.sv
// Shared definitions for the fig_14 nibble-serial adder: operand/digit widths and FSM encodings.
package fig_14_nibble_serial_adder_pkg;

   localparam int FIG14_WIDTH = 13;
   localparam int FIG14_DIGIT = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/fig_14_nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// Flag signals exist only when FIG14_ADDER_FLAGS_EN is defined.
interface fig_14_nibble_serial_adder_if
   import fig_14_nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = FIG14_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
`ifdef FIG14_ADDER_FLAGS_EN
   logic             carry_out;
   logic             zero;
`endif

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum
`ifdef FIG14_ADDER_FLAGS_EN
      , input carry_out, zero
`endif
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum
`ifdef FIG14_ADDER_FLAGS_EN
      , output carry_out, zero
`endif
   );

endinterface

// File: rtl/fig_14_nibble_serial_adder_digit.sv
// 4-bit carry-lookahead digit adder: four propagate/generate full-adder cells
// whose carries come from a shared 4-bit lookahead block.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic p,
   output logic g
);
   assign p = a ^ b;
   assign g = a & b;
   assign s = p ^ c_in;
endmodule

module carry_lookahead_logic_4_bit (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       c_in,
   output logic [3:0] c,
   output logic       c_out
);
   // c[i] is the carry into bit i
   assign c[0]  = c_in;
   assign c[1]  = g[0] | (p[0] & c_in);
   assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
   assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);
endmodule

module fig_14_digit_adder_4_bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .c_in (c[i]),
         .s    (s[i]),
         .p    (p[i]),
         .g    (g[i])
      );
   end

   carry_lookahead_logic_4_bit u_cla (
      .p     (p),
      .g     (g),
      .c_in  (c_in),
      .c     (c),
      .c_out (c_out)
   );
endmodule

// File: rtl/fig_14_nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit CLA stage time-shared over NDIG clocks to form (a+b) mod 2^WIDTH.
// Optional carry_out/zero flags are built when FIG14_ADDER_FLAGS_EN is defined.
//
// state  | meaning
// S_IDLE | in_ready=1, waiting for operands
// S_ADD  | one digit summed per clock, cnt selects the digit
// S_DONE | out_valid=1, result held until out_ready
module fig_14_nibble_serial_adder
   import fig_14_nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = FIG14_WIDTH,
   parameter int DIGIT = FIG14_DIGIT
)(
   input  logic                         clk,
   input  logic                         rst_n,
   fig_14_nibble_serial_adder_if.slave  bus
);
   localparam int NDIG     = ceil_div(WIDTH, DIGIT);
   localparam int PW       = NDIG * DIGIT;
   localparam int TOP_BITS = WIDTH - (NDIG - 1) * DIGIT;
   localparam int CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, sum_q, sum_final;
   logic             carry_q, carry_nxt;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    a_pad, b_pad;
   logic [DIGIT-1:0] a_dig, b_dig, s_dig;
   logic             c_dig;
   logic             last_dig;

   assign a_pad    = PW'(a_q);
   assign b_pad    = PW'(b_q);
   assign a_dig    = a_pad[int'(cnt)*DIGIT +: DIGIT];
   assign b_dig    = b_pad[int'(cnt)*DIGIT +: DIGIT];
   assign last_dig = (cnt == LAST);

   fig_14_digit_adder_4_bit u_digit (
      .a     (a_dig),
      .b     (b_dig),
      .c_in  (carry_q),
      .s     (s_dig),
      .c_out (c_dig)
   );

   // Top digit is zero-padded, so bit WIDTH-1's carry lands in the first padding lane of s_dig.
   assign carry_nxt = last_dig ? s_dig[TOP_BITS] : c_dig;
   assign sum_final = {s_dig[TOP_BITS-1:0], sum_q[WIDTH-TOP_BITS-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.in_valid)  state_nxt = S_ADD;
         S_ADD:   if (last_dig)      state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
         default:                    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == S_IDLE);
      bus.out_valid = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               a_q     <= bus.a;
               b_q     <= bus.b;
               carry_q <= 1'b0;
               cnt     <= '0;
            end
            S_ADD: begin
               carry_q <= carry_nxt;
               cnt     <= cnt + 1'b1;
               if (last_dig) sum_q <= sum_final;
               for (int k = 0; k < NDIG - 1; k++)
                  if (cnt == CW'(k)) sum_q[k*DIGIT +: DIGIT] <= s_dig;
            end
            default: ;
         endcase
      end
   end

   assign bus.sum = sum_q;

`ifdef FIG14_ADDER_FLAGS_EN
   logic carry_out_q, zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_out_q <= 1'b0;
         zero_q      <= 1'b0;
      end else if (state == S_ADD && last_dig) begin
         carry_out_q <= carry_nxt;
         zero_q      <= (sum_final == '0);
      end
   end

   assign bus.carry_out = carry_out_q;
   assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_fig_14_nibble_serial_adder.sv
// Directed and random checks of the nibble-serial adder; define FIG14_ADDER_FLAGS_EN to also check flags.
module tb_fig_14_nibble_serial_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fig_14_nibble_serial_adder_if #(.WIDTH(13)) bus();

   fig_14_nibble_serial_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic get_co();
`ifdef FIG14_ADDER_FLAGS_EN
      return bus.carry_out;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic get_z();
`ifdef FIG14_ADDER_FLAGS_EN
      return bus.zero;
`else
      return 1'b0;
`endif
   endfunction

   // Drives one operation from IDLE through consumption; reports what was observed.
   task automatic run_op(input logic [12:0] x, input logic [12:0] y, input int stall,
                         output logic [12:0] s, output int lat, output logic co,
                         output logic z, output logic ov_after);
      bus.a = x; bus.b = y; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = ~x; bus.b = ~y;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      repeat (stall) begin @(posedge clk); #1; end
      s  = bus.sum;
      co = get_co();
      z  = get_z();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      ov_after = bus.out_valid;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.sum !== 13'h0000) begin n_err++; $display("FAIL reset_sum got %h want 0000", bus.sum); end
`ifdef FIG14_ADDER_FLAGS_EN
      n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b%b want 00", bus.carry_out, bus.zero); end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [12:0] s; int lat; logic co, z, ov;
      run_op(13'h0005, 13'h0003, 0, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h0008) begin n_err++; $display("FAIL basic_sum got %h want 0008", s); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", lat); end
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL basic_release got %b want 0", ov); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
`ifdef FIG14_ADDER_FLAGS_EN
      n_cmp++; if ({co, z} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b%b want 00", co, z); end
`endif
   endtask

   task automatic test_carry_chain();
      logic [12:0] s; int lat; logic co, z, ov;
      run_op(13'h00FF, 13'h0001, 1, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h0100) begin n_err++; $display("FAIL chain_ff_sum got %h want 0100", s); end
      run_op(13'h0FFF, 13'h0001, 0, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h1000) begin n_err++; $display("FAIL chain_fff_sum got %h want 1000", s); end
`ifdef FIG14_ADDER_FLAGS_EN
      n_cmp++; if ({co, z} !== 2'b00) begin n_err++; $display("FAIL chain_flags got %b%b want 00", co, z); end
`endif
   endtask

   task automatic test_overflow();
      logic [12:0] s; int lat; logic co, z, ov;
      run_op(13'h1FFF, 13'h0001, 0, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h0000) begin n_err++; $display("FAIL wrap_sum got %h want 0000", s); end
`ifdef FIG14_ADDER_FLAGS_EN
      n_cmp++; if ({co, z} !== 2'b11) begin n_err++; $display("FAIL wrap_flags got %b%b want 11", co, z); end
`endif
      run_op(13'h1000, 13'h1000, 0, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h0000) begin n_err++; $display("FAIL top_bit_sum got %h want 0000", s); end
      run_op(13'h1FFF, 13'h1FFF, 0, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h1FFE) begin n_err++; $display("FAIL max_sum got %h want 1ffe", s); end
`ifdef FIG14_ADDER_FLAGS_EN
      n_cmp++; if ({co, z} !== 2'b10) begin n_err++; $display("FAIL max_flags got %b%b want 10", co, z); end
`endif
   endtask

   task automatic test_async_reset();
      int lat;
      bus.a = 13'h0005; bus.b = 13'h0003; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (bus.sum !== 13'h0008) begin n_err++; $display("FAIL arst_pre_sum got %h want 0008", bus.sum); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.sum !== 13'h0000) begin n_err++; $display("FAIL arst_sum got %h want 0000", bus.sum); end
`ifdef FIG14_ADDER_FLAGS_EN
      n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b00) begin n_err++; $display("FAIL arst_flags got %b%b want 00", bus.carry_out, bus.zero); end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      int lat; int bad;
      bus.a = 13'h0100; bus.b = 13'h0023; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL stall_latency got %0d want 4", lat); end
      bus.a = 13'h0555; bus.b = 13'h0111; bus.in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (bus.sum !== 13'h0123) begin n_err++; $display("FAIL stall_sum cycle %0d got %h want 0123", i, bus.sum); end
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cycle %0d got %b want 0", i, bus.in_ready); end
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid cycle %0d got %b want 1", i, bus.out_valid); end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_cmp++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin n_err++; $display("FAIL stall_release got %b%b want 10", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_reset_mid_add();
      logic [12:0] s; int lat; logic co, z, ov; int stray;
      bus.a = 13'h0FFF; bus.b = 13'h0FFF; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) stray++;
      end
      n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL midrst_stray got %0d want 0", stray); end
      run_op(13'h1234, 13'h0ABC, 0, s, lat, co, z, ov);
      n_cmp++; if (s !== 13'h1CF0) begin n_err++; $display("FAIL midrst_sum got %h want 1cf0", s); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL midrst_latency got %0d want 4", lat); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] x, y, s; int lat; logic co, z, ov; logic [13:0] full;
      for (int i = 0; i < 24; i++) begin
         x = 13'($urandom_range(0, 8191));
         y = 13'($urandom_range(0, 8191));
         full = {1'b0, x} + {1'b0, y};
         run_op(x, y, int'($urandom_range(0, 3)), s, lat, co, z, ov);
         n_cmp++; if (s !== full[12:0]) begin n_err++; $display("FAIL rand_sum %h+%h got %h want %h", x, y, s, full[12:0]); end
         n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rand_latency got %0d want 4", lat); end
         n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL rand_single_result got %b want 0", ov); end
`ifdef FIG14_ADDER_FLAGS_EN
         n_cmp++; if ({co, z} !== {full[13], full[12:0] == 13'h0}) begin n_err++; $display("FAIL rand_flags got %b%b want %b%b", co, z, full[13], full[12:0] == 13'h0); end
`endif
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      test_reset();
      test_basic();
      test_carry_chain();
      test_overflow();
      test_async_reset();
      test_stall();
      test_reset_mid_add();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
